// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one 8-bit ALU between two requesters.
// Each op is held on the ALU bus for WAIT_CYCLES, then the result is returned with a 1-cycle pulse.
module alu_share_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [2:0] req0_select,
  input  logic [7:0] req0_data1,
  input  logic [7:0] req0_data2,
  output logic       resp0_valid,
  output logic [7:0] resp0_result,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [2:0] req1_select,
  input  logic [7:0] req1_data1,
  input  logic [7:0] req1_data2,
  output logic       resp1_valid,
  output logic [7:0] resp1_result,
  output logic [2:0] alu_select,
  output logic [7:0] alu_data1,
  output logic [7:0] alu_data2,
  input  logic [7:0] alu_result,
  output logic       busy
);

  localparam logic [3:0] CntLast = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic       owner_q, owner_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] alu_select_q, alu_select_d;
  logic [7:0] alu_data1_q, alu_data1_d;
  logic [7:0] alu_data2_q, alu_data2_d;
  logic [7:0] resp0_result_q, resp0_result_d;
  logic [7:0] resp1_result_q, resp1_result_d;
  logic       hs0, hs1;

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers; last_grant resets to 1 so req0 wins the first contention
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      last_grant_q   <= 1'b1;
      owner_q        <= 1'b0;
      cnt_q          <= 4'd0;
      alu_select_q   <= 3'd0;
      alu_data1_q    <= 8'd0;
      alu_data2_q    <= 8'd0;
      resp0_result_q <= 8'd0;
      resp1_result_q <= 8'd0;
    end else begin
      last_grant_q   <= last_grant_d;
      owner_q        <= owner_d;
      cnt_q          <= cnt_d;
      alu_select_q   <= alu_select_d;
      alu_data1_q    <= alu_data1_d;
      alu_data2_q    <= alu_data2_d;
      resp0_result_q <= resp0_result_d;
      resp1_result_q <= resp1_result_d;
    end
  end

  assign hs0 = req0_valid & req0_ready;
  assign hs1 = req1_valid & req1_ready;

  // Next-state and datapath updates
  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    owner_d        = owner_q;
    cnt_d          = cnt_q;
    alu_select_d   = alu_select_q;
    alu_data1_d    = alu_data1_q;
    alu_data2_d    = alu_data2_q;
    resp0_result_d = resp0_result_q;
    resp1_result_d = resp1_result_q;
    unique case (state_q)
      StIdle: begin
        if (hs0) begin
          alu_select_d = req0_select;
          alu_data1_d  = req0_data1;
          alu_data2_d  = req0_data2;
          owner_d      = 1'b0;
          last_grant_d = 1'b0;
          cnt_d        = 4'd0;
          state_d      = StWait;
        end else if (hs1) begin
          alu_select_d = req1_select;
          alu_data1_d  = req1_data1;
          alu_data2_d  = req1_data2;
          owner_d      = 1'b1;
          last_grant_d = 1'b1;
          cnt_d        = 4'd0;
          state_d      = StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CntLast) begin
          if (owner_q) begin
            resp1_result_d = alu_result;
          end else begin
            resp0_result_d = alu_result;
          end
          state_d = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs; readys are mutually exclusive when both requesters are valid
  always_comb begin
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    busy        = (state_q != StIdle);
    if (state_q == StIdle) begin
      req0_ready = ~req1_valid | last_grant_q;
      req1_ready = ~req0_valid | ~last_grant_q;
    end
    if (state_q == StResp) begin
      resp0_valid = ~owner_q;
      resp1_valid = owner_q;
    end
  end

  assign alu_select   = alu_select_q;
  assign alu_data1    = alu_data1_q;
  assign alu_data2    = alu_data2_q;
  assign resp0_result = resp0_result_q;
  assign resp1_result = resp1_result_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed op table plus reset, contention and abort
// sequences against a small behavioural ALU.
module tb_alu_share_arbiter;

  localparam int unsigned WaitCycles = 2;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       req0_valid, req0_ready, resp0_valid;
  logic [2:0] req0_select;
  logic [7:0] req0_data1, req0_data2, resp0_result;
  logic       req1_valid, req1_ready, resp1_valid;
  logic [2:0] req1_select;
  logic [7:0] req1_data1, req1_data2, resp1_result;
  logic [2:0] alu_select;
  logic [7:0] alu_data1, alu_data2, alu_result;
  logic       busy;

  int n_chk = 0;
  int n_err = 0;

  alu_share_arbiter #(.WAIT_CYCLES(WaitCycles)) dut (
    .CLK(CLK), .RESET(RESET),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_select(req0_select),
    .req0_data1(req0_data1), .req0_data2(req0_data2),
    .resp0_valid(resp0_valid), .resp0_result(resp0_result),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_select(req1_select),
    .req1_data1(req1_data1), .req1_data2(req1_data2),
    .resp1_valid(resp1_valid), .resp1_result(resp1_result),
    .alu_select(alu_select), .alu_data1(alu_data1), .alu_data2(alu_data2),
    .alu_result(alu_result), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Behavioural ALU; reserved codes return a recognisable constant
  always_comb begin
    case (alu_select)
      3'd0:    alu_result = alu_data2;
      3'd1:    alu_result = alu_data1 + alu_data2;
      3'd2:    alu_result = alu_data1 & alu_data2;
      3'd3:    alu_result = alu_data1 | alu_data2;
      default: alu_result = 8'hEE;
    endcase
  end

  typedef struct {
    bit         port;
    logic [2:0] sel;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [7:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input bit port, input logic v, input logic [2:0] sel,
                         input logic [7:0] d1, input logic [7:0] d2);
    if (port) begin
      req1_valid = v; req1_select = sel; req1_data1 = d1; req1_data2 = d2;
    end else begin
      req0_valid = v; req0_select = sel; req0_data1 = d1; req0_data2 = d2;
    end
  endtask

  // Handshake a lone request; returns at the first negedge after the handshake edge
  task automatic start_op(input bit port, input logic [2:0] sel, input logic [7:0] d1,
                          input logic [7:0] d2);
    bit ok;
    ok = 1'b0;
    @(negedge CLK);
    set_req(port, 1'b1, sel, d1, d2);
    for (int i = 0; i < 20; i++) begin
      #1;
      if (port ? req1_ready : req0_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    chk("handshake", 32'(ok), 32'd1);
    @(negedge CLK);
    set_req(port, 1'b0, 3'd0, 8'd0, 8'd0);
  endtask

  task automatic wait_resp(input bit port, output logic [7:0] res, output int lat,
                           output bit other);
    bit found;
    found = 1'b0;
    lat   = 1;
    other = 1'b0;
    res   = 8'd0;
    while (!found && lat < 40) begin
      if (port ? resp1_valid : resp0_valid) begin
        found = 1'b1;
        res   = port ? resp1_result : resp0_result;
      end else begin
        if (port ? resp0_valid : resp1_valid) other = 1'b1;
        @(negedge CLK);
        lat++;
      end
    end
  endtask

  initial begin
    vec_t       vecs[7];
    logic [7:0] res;
    logic [7:0] last[2];
    int         lat;
    bit         other;
    int         order[6];
    int         when[6];
    int         nresp;
    int         seen;

    vecs[0] = '{1'b0, 3'd1, 8'h05, 8'h03, 8'h08};
    vecs[1] = '{1'b1, 3'd1, 8'hFF, 8'h02, 8'h01};
    vecs[2] = '{1'b0, 3'd0, 8'h3C, 8'hA5, 8'hA5};
    vecs[3] = '{1'b1, 3'd2, 8'hF0, 8'h3C, 8'h30};
    vecs[4] = '{1'b0, 3'd3, 8'hF0, 8'h0F, 8'hFF};
    vecs[5] = '{1'b1, 3'd5, 8'h12, 8'h34, 8'hEE};
    vecs[6] = '{1'b0, 3'd1, 8'h80, 8'h81, 8'h01};

    RESET = 1'b1;
    set_req(1'b0, 1'b0, 3'd0, 8'd0, 8'd0);
    set_req(1'b1, 1'b0, 3'd0, 8'd0, 8'd0);
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    chk("reset_outputs", {alu_select, alu_data1, alu_data2, resp0_result, resp1_result,
                          resp0_valid, resp1_valid, busy}, 32'd0);
    last[0] = 8'd0;
    last[1] = 8'd0;

    // Directed single ops from the table
    foreach (vecs[i]) begin
      start_op(vecs[i].port, vecs[i].sel, vecs[i].d1, vecs[i].d2);
      chk("alu_select_passthru", 32'(alu_select), 32'(vecs[i].sel));
      chk("busy_in_wait", 32'(busy), 32'd1);
      wait_resp(vecs[i].port, res, lat, other);
      chk("op_result", 32'(res), 32'(vecs[i].exp));
      chk("op_latency", 32'(lat), 32'(WaitCycles + 1));
      chk("other_resp_quiet", 32'(other), 32'd0);
      chk("other_result_held", 32'(vecs[i].port ? resp0_result : resp1_result),
          32'(last[!vecs[i].port]));
      last[vecs[i].port] = vecs[i].exp;
      @(negedge CLK);
      chk("resp_pulse_width", 32'({resp0_valid, resp1_valid}), 32'd0);
      chk("idle_after_resp", 32'(busy), 32'd0);
      chk("result_held", 32'(vecs[i].port ? resp1_result : resp0_result), 32'(vecs[i].exp));
    end

    // Reset asserted mid-WAIT clears everything immediately
    start_op(1'b1, 3'd3, 8'h5A, 8'hA5);
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    chk("midsim_reset_alu", {alu_select, alu_data1, alu_data2}, 32'd0);
    chk("midsim_reset_resp", {resp0_result, resp1_result, resp0_valid, resp1_valid}, 32'd0);
    chk("midsim_reset_busy", 32'(busy), 32'd0);
    @(negedge CLK);
    RESET = 1'b0;

    // Contention and fairness: both held valid for six ops
    set_req(1'b0, 1'b1, 3'd2, 8'hF0, 8'h3C);
    set_req(1'b1, 1'b1, 3'd3, 8'hF0, 8'h0F);
    #1;
    chk("first_contention_ready", {req0_ready, req1_ready}, 32'b10);
    nresp = 0;
    for (int c = 0; c < 60 && nresp < 6; c++) begin
      @(negedge CLK);
      if (resp0_valid && resp1_valid) begin
        chk("both_resp_valid", 32'd1, 32'd0);
      end else if (resp0_valid || resp1_valid) begin
        order[nresp] = resp1_valid ? 1 : 0;
        when[nresp]  = c;
        chk("contention_result", 32'(resp1_valid ? resp1_result : resp0_result),
            resp1_valid ? 32'hFF : 32'h30);
        nresp++;
      end
    end
    set_req(1'b0, 1'b0, 3'd0, 8'd0, 8'd0);
    set_req(1'b1, 1'b0, 3'd0, 8'd0, 8'd0);
    chk("fairness_count", 32'(nresp), 32'd6);
    for (int k = 0; k < nresp; k++) begin
      chk("grant_order", 32'(order[k]), 32'(k % 2));
      if (k > 0) chk("op_spacing", 32'(when[k] - when[k-1]), 32'(WaitCycles + 2));
    end
    @(negedge CLK);
    chk("contention_pulse_width", 32'({resp0_valid, resp1_valid}), 32'd0);
    @(negedge CLK);

    // Abort: reset during WAIT of a req0 op suppresses its response
    start_op(1'b0, 3'd1, 8'h11, 8'h22);
    RESET = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      if (resp0_valid || resp1_valid) seen++;
    end
    chk("abort_no_resp", 32'(seen), 32'd0);
    start_op(1'b0, 3'd1, 8'h01, 8'h02);
    wait_resp(1'b0, res, lat, other);
    chk("after_abort_result", 32'(res), 32'h03);
    chk("after_abort_latency", 32'(lat), 32'(WaitCycles + 1));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
